lu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 32-bit bitwise logic unit (lu).

---
 rtl/lu_result_stage.sv | 230 +++++++++++++++++++++++
 tb/tb_lu_result_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lu_result_stage.sv
// ---------------------------------------------------------------------------
// lu_result_stage
//
// Registered output stage that sits directly behind the 32-bit bitwise logic
// unit. Each accepted lu result is captured together with its destination
// register index and handed to the register-file write port through a
// valid/ready handshake. A two-entry skid buffer (head + skid) absorbs
// write-port stalls so that no result is ever lost. Writes that target
// register 0 are consumed but squashed: they never enter the buffer and are
// never counted.
//
// Parameters
//   DW     datapath width (lu out[31:0])
//   AW     register index width
//   CNT_W  width of the retired-result counter (wraps modulo 2^CNT_W)
//
// Ports
//   clk       in   1      rising-edge clock
//   rst       in   1      synchronous reset, active-high
//   in_valid  in   1      lu result on in_data is valid
//   in_ready  out  1      stage can accept (transfer on in_valid & in_ready)
//   in_data   in   DW     lu result
//   in_rd     in   AW     destination register index
//   in_sel    in   4      lu operation select, carried for trace/flags
//   wb_valid  out  1      register-file write request
//   wb_ready  in   1      register file accepts (transfer on wb_valid & wb_ready)
//   wb_addr   out  AW     write index (head entry)
//   wb_data   out  DW     write data  (head entry)
//   retired   out  CNT_W  number of results delivered on the wb port
//
// Optional feature (macro LU_RESULT_FLAGS_EN)
//   When defined, three extra outputs describe the head entry:
//     wb_zero  out 1  head data == 0
//     wb_ones  out 1  head data is all ones
//     wb_sel   out 4  head entry's in_sel
//   Flags are computed at capture time, stored per entry and follow the head.
//   When undefined, these ports and their storage are absent and in_sel is
//   ignored.
// ---------------------------------------------------------------------------
module lu_result_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [AW-1:0]    in_rd,
  input  logic [3:0]       in_sel,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [AW-1:0]    wb_addr,
  output logic [DW-1:0]    wb_data,
  output logic [CNT_W-1:0] retired
`ifdef LU_RESULT_FLAGS_EN
  ,
  output logic             wb_zero,
  output logic             wb_ones,
  output logic [3:0]       wb_sel
`endif
);

  // Buffer occupancy. EMPTY: nothing held; ONE: head valid; FULL: head and
  // skid both valid.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [AW-1:0]    r_head_addr;
  logic [DW-1:0]    r_head_data;
  logic [AW-1:0]    r_skid_addr;
  logic [DW-1:0]    r_skid_data;
  logic [CNT_W-1:0] r_retired;

  logic             w_push;
  logic             w_pop;
  logic             w_load_head;      // capture input into head
  logic             w_head_from_skid; // promote skid entry to head
  logic             w_load_skid;      // capture input into skid

`ifdef LU_RESULT_FLAGS_EN
  logic             r_head_zero;
  logic             r_head_ones;
  logic [3:0]       r_head_sel;
  logic             r_skid_zero;
  logic             r_skid_ones;
  logic [3:0]       r_skid_sel;
  logic             w_in_zero;
  logic             w_in_ones;
`else
  logic             w_unused_sel;
`endif

  // in_ready depends only on registered state (and reset), so there is no
  // combinational path from wb_ready back to the producer.
  assign in_ready = (r_state != S_FULL) & ~rst;

  // wb_valid is masked during reset so no write transfer can occur in the
  // reset cycle, even when the buffer still holds entries.
  assign wb_valid = (r_state != S_EMPTY) & ~rst;
  assign wb_addr  = r_head_addr;
  assign wb_data  = r_head_data;
  assign retired  = r_retired;

  // Register-0 writes are accepted (handshake honoured) but never buffered.
  assign w_push = in_valid & in_ready & (in_rd != '0);
  assign w_pop  = wb_valid & wb_ready;

  // Next-state and buffer steering.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_load_head = 1'b1;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          // Head leaves this cycle, so the new entry goes straight to head.
          w_load_head = 1'b1;
        end else if (w_push) begin
          w_state_nxt = S_FULL;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (w_pop) begin
          w_state_nxt      = S_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Head and skid storage. The head only changes on a load, so wb_addr and
  // wb_data hold steady while the write port stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_addr <= '0;
      r_head_data <= '0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_head) begin
        r_head_addr <= in_rd;
        r_head_data <= in_data;
      end else if (w_head_from_skid) begin
        r_head_addr <= r_skid_addr;
        r_head_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_addr <= in_rd;
        r_skid_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired <= '0;
    end else if (w_pop) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

`ifdef LU_RESULT_FLAGS_EN
  assign w_in_zero = (in_data == '0);
  assign w_in_ones = (in_data == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_zero <= 1'b0;
      r_head_ones <= 1'b0;
      r_head_sel  <= '0;
      r_skid_zero <= 1'b0;
      r_skid_ones <= 1'b0;
      r_skid_sel  <= '0;
    end else begin
      if (w_load_head) begin
        r_head_zero <= w_in_zero;
        r_head_ones <= w_in_ones;
        r_head_sel  <= in_sel;
      end else if (w_head_from_skid) begin
        r_head_zero <= r_skid_zero;
        r_head_ones <= r_skid_ones;
        r_head_sel  <= r_skid_sel;
      end
      if (w_load_skid) begin
        r_skid_zero <= w_in_zero;
        r_skid_ones <= w_in_ones;
        r_skid_sel  <= in_sel;
      end
    end
  end

  assign wb_zero = r_head_zero;
  assign wb_ones = r_head_ones;
  assign wb_sel  = r_head_sel;
`else
  // Trace select has no consumer without the flag outputs.
  assign w_unused_sel = ^in_sel;
`endif

endmodule

// File: tb/tb_lu_result_stage.sv
// ---------------------------------------------------------------------------
// tb_lu_result_stage
//
// Self-checking bench for lu_result_stage. A FIFO model (queue of entries,
// capacity two, plus an integer retire count) predicts every output each
// cycle; a second instance with a 4-bit counter shares the stimulus so the
// counter wrap is exercised continuously. Directed sequences pin the model
// with literal expectations, then randomized traffic runs against it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lu_result_stage;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 16;
  localparam int SW    = 4;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             in_valid = 1'b0;
  logic [DW-1:0]    in_data  = '0;
  logic [AW-1:0]    in_rd    = '0;
  logic [3:0]       in_sel   = '0;
  logic             wb_ready = 1'b0;

  logic             in_ready, wb_valid;
  logic [AW-1:0]    wb_addr;
  logic [DW-1:0]    wb_data;
  logic [CNT_W-1:0] retired;

  logic             s_in_ready, s_wb_valid;
  logic [AW-1:0]    s_wb_addr;
  logic [DW-1:0]    s_wb_data;
  logic [SW-1:0]    s_retired;

`ifdef LU_RESULT_FLAGS_EN
  logic             wb_zero, wb_ones, s_wb_zero, s_wb_ones;
  logic [3:0]       wb_sel, s_wb_sel;
`endif

  always #5 clk = ~clk;

  lu_result_stage #(.DW(DW), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_sel(in_sel),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .wb_data(wb_data), .retired(retired)
`ifdef LU_RESULT_FLAGS_EN
    , .wb_zero(wb_zero), .wb_ones(wb_ones), .wb_sel(wb_sel)
`endif
  );

  lu_result_stage #(.DW(DW), .AW(AW), .CNT_W(SW)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_sel(in_sel),
    .wb_valid(s_wb_valid), .wb_ready(wb_ready), .wb_addr(s_wb_addr),
    .wb_data(s_wb_data), .retired(s_retired)
`ifdef LU_RESULT_FLAGS_EN
    , .wb_zero(s_wb_zero), .wb_ones(s_wb_ones), .wb_sel(s_wb_sel)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
  } ent_t;

  ent_t        q[$];
  int unsigned m_ret      = 0;
  bit          m_post_rst = 1'b1;
  int          total      = 0;
  int          bad        = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model compare + advance, once per cycle, mid low phase.
  initial begin : compare
    bit exp_rdy, exp_vld;
    forever begin
      @(negedge clk);
      #3;
      exp_rdy = (q.size() < 2) && !rst;
      exp_vld = (q.size() > 0) && !rst;
      chk("in_ready", in_ready, exp_rdy);
      chk("wb_valid", wb_valid, exp_vld);
      chk("w4_in_ready", s_in_ready, exp_rdy);
      chk("w4_wb_valid", s_wb_valid, exp_vld);
      if (q.size() > 0) begin
        chk("wb_addr", wb_addr, q[0].a);
        chk("wb_data", wb_data, q[0].d);
        chk("w4_wb_addr", s_wb_addr, q[0].a);
        chk("w4_wb_data", s_wb_data, q[0].d);
`ifdef LU_RESULT_FLAGS_EN
        chk("wb_zero", wb_zero, q[0].d == 0);
        chk("wb_ones", wb_ones, q[0].d == {DW{1'b1}});
        chk("wb_sel", wb_sel, q[0].s);
        chk("w4_wb_sel", s_wb_sel, q[0].s);
`endif
      end else if (m_post_rst) begin
        chk("rst_wb_addr", wb_addr, 0);
        chk("rst_wb_data", wb_data, 0);
`ifdef LU_RESULT_FLAGS_EN
        chk("rst_wb_zero", wb_zero, 0);
        chk("rst_wb_ones", wb_ones, 0);
        chk("rst_wb_sel", wb_sel, 0);
`endif
      end
      chk("retired", retired, m_ret & 32'hFFFF);
      chk("w4_retired", s_retired, m_ret & 32'hF);
      if (rst) begin
        q.delete();
        m_ret      = 0;
        m_post_rst = 1'b1;
      end else begin
        if (exp_vld && wb_ready) begin
          void'(q.pop_front());
          m_ret++;
        end
        if (in_valid && exp_rdy && in_rd != 0) begin
          q.push_back('{a: in_rd, d: in_data, s: in_sel});
          m_post_rst = 1'b0;
        end
      end
    end
  end

  task automatic drv(input logic v, input logic [AW-1:0] rd,
                     input logic [DW-1:0] d, input logic [3:0] sel,
                     input logic wr);
    @(negedge clk);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    in_sel   = sel;
    wb_ready = wr;
  endtask

  initial begin : stim
    int vcnt;
    // Two reset cycles.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("T1 wb_valid", wb_valid, 0);
    chk("T1 in_ready", in_ready, 0);
    chk("T1 retired", retired, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("T1 in_ready_after", in_ready, 1);

    // Single transfer, 1-cycle latency.
    drv(1, 5'd3, 32'hA5A5_0F0F, 4'd5, 1);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T2 wb_valid", wb_valid, 1);
    chk("T2 wb_addr", wb_addr, 3);
    chk("T2 wb_data", wb_data, 32'hA5A5_0F0F);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T2 retired", retired, 1);
    chk("T2 wb_valid_off", wb_valid, 0);

    // Stall: fill both entries, third input held, then drain in order.
    drv(1, 5'd1, 32'h1, 4'd1, 0);
    drv(1, 5'd2, 32'h2, 4'd2, 0);
    #1;
    chk("T3 in_ready_one", in_ready, 1);
    drv(1, 5'd3, 32'h3, 4'd3, 0);
    #1;
    chk("T3 in_ready_full", in_ready, 0);
    chk("T3 head1", wb_data, 32'h1);
    drv(1, 5'd3, 32'h3, 4'd3, 0);
    #1;
    chk("T3 head1_stable", wb_data, 32'h1);
    drv(1, 5'd3, 32'h3, 4'd3, 1);
    #1;
    chk("T3 deliver1", wb_data, 32'h1);
    drv(1, 5'd3, 32'h3, 4'd3, 1);
    #1;
    chk("T3 deliver2", wb_data, 32'h2);
    chk("T3 in_ready_again", in_ready, 1);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T3 deliver3", wb_data, 32'h3);
    chk("T3 addr3", wb_addr, 3);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T3 empty", wb_valid, 0);
    chk("T3 retired", retired, 4);

    // Squashed rd==0 write.
    drv(1, 5'd0, 32'hFFFF_FFFF, 4'd0, 1);
    #1;
    chk("T4 in_ready", in_ready, 1);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T4 wb_valid", wb_valid, 0);
    chk("T4 retired", retired, 4);

    // Back-to-back stream of 8.
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      drv(1, AW'(i + 1), 32'h1000_0000 + DW'(i), 4'(i), 1);
      #1;
      if (i > 0 && wb_valid) vcnt++;
    end
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    if (wb_valid) vcnt++;
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("T5 consecutive", vcnt, 8);
    chk("T5 retired", retired, 12);
    chk("T5 w4_wrapped", s_retired, 12);

`ifdef LU_RESULT_FLAGS_EN
    drv(1, 5'd7, 32'h0, 4'd9, 1);
    drv(1, 5'd8, 32'hFFFF_FFFF, 4'd10, 1);
    #1;
    chk("TF wb_zero", wb_zero, 1);
    chk("TF wb_sel", wb_sel, 9);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    #1;
    chk("TF wb_ones", wb_ones, 1);
    chk("TF wb_zero_off", wb_zero, 0);
`endif

    // Reset while FULL discards both entries.
    drv(1, 5'd9, 32'h99, 4'd0, 0);
    drv(1, 5'd10, 32'hAA, 4'd0, 0);
    drv(0, 5'd0, 32'h0, 4'd0, 0);
    #1;
    chk("T6 full_valid", wb_valid, 1);
    chk("T6 full_ready", in_ready, 0);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    rst = 1'b1;
    #1;
    chk("T6 rst_cycle_valid", wb_valid, 0);
    drv(0, 5'd0, 32'h0, 4'd0, 1);
    rst = 1'b0;
    #1;
    chk("T6 after_valid", wb_valid, 0);
    chk("T6 after_retired", retired, 0);
    for (int i = 0; i < 2; i++) begin
      drv(0, 5'd0, 32'h0, 4'd0, 1);
      #1;
      chk("T6 no_ghost", wb_valid, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 199) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      in_rd    = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
      case ($urandom_range(0, 9))
        0:       in_data = '0;
        1:       in_data = '1;
        default: in_data = $urandom;
      endcase
      in_sel   = 4'($urandom);
      if (n < 1500) wb_ready = ($urandom_range(0, 3) != 0);
      else          wb_ready = ($urandom_range(0, 9) < 3);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    wb_ready = 1'b1;
    repeat (4) @(negedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
